// File: rtl/ulpi_rx_buf.sv
`default_nettype none
// ============================================================================
// Module   : ulpi_rx_buf
// Purpose  : ULPI receive-side capture and buffer. Tracks PHY bus ownership
//            (DIR), separates packet bytes (NXT=1) from RX CMD bytes (NXT=0)
//            while the PHY drives the bus, and stores packet bytes in a
//            DEPTH-byte FIFO that a consumer drains with a one-cycle pop
//            latency. A dropped byte sets a sticky overflow flag.
// Revision : 1.0 - initial release
//
// Ports
//   i_clk        ULPI 60 MHz clock, all logic on rising edge
//   i_rst_n      asynchronous active-low reset
//   i_dir/i_nxt  ULPI DIR / NXT from the PHY
//   i_data       ULPI DATA as sampled from the bus
//   i_clr        synchronous flush of FIFO and overflow flag
//   i_rd_en      pop request
//   o_rd_data    popped byte (registered), o_rd_vld one-cycle strobe
//   o_count      bytes held; o_empty / o_full / o_overflow status
//   o_rxcmd      last RX CMD byte, o_rxcmd_vld one-cycle update strobe
//   o_pkt_end    pulse after a bus turn that carried packet bytes
//   o_pkt_total / o_drop_total  saturating statistics (ULPI_RX_STATS_EN only)
//
// Configuration macro: ULPI_RX_STATS_EN adds the two statistics counters.
// ============================================================================
module ulpi_rx_buf #(
  parameter int  DEPTH = 32,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_dir,
  input  logic             i_nxt,
  input  logic [7:0]       i_data,
  input  logic             i_clr,
  input  logic             i_rd_en,
  output logic [7:0]       o_rd_data,
  output logic             o_rd_vld,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow,
  output logic [7:0]       o_rxcmd,
  output logic             o_rxcmd_vld,
`ifdef ULPI_RX_STATS_EN
  output logic [15:0]      o_pkt_total,
  output logic [15:0]      o_drop_total,
`endif
  output logic             o_pkt_end
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    TURN = 2'd2,
    RECV = 2'd3
  } state_t;

  state_t state, state_n;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             seen_byte;   // a packet byte arrived in the current turn

  logic             push_req, cmd_req, end_req;
  logic             pop_ok, push_ok, drop;
  logic [CNT_W-1:0] count_n;

  // Next-state and bus decode
  always_comb begin
    state_n  = state;
    push_req = 1'b0;
    cmd_req  = 1'b0;
    end_req  = 1'b0;
    case (state)
      // Stay here until the PHY releases the bus, so a reset in the middle
      // of a packet never captures the tail of that packet.
      SYNC: if (!i_dir) state_n = IDLE;
      IDLE: if (i_dir) state_n = TURN;
      TURN: state_n = i_dir ? RECV : IDLE;
      RECV: begin
        if (i_dir) begin
          push_req = i_nxt;
          cmd_req  = !i_nxt;
        end else begin
          end_req  = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = SYNC;
    endcase
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO
  // succeeds when it coincides with a pop. An empty FIFO never bypasses.
  always_comb begin
    pop_ok  = i_rd_en && !o_empty;
    push_ok = push_req && (!o_full || pop_ok);
    drop    = push_req && !push_ok;
    count_n = o_count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= SYNC;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_count      <= '0;
      o_empty      <= 1'b1;
      o_full       <= 1'b0;
      o_overflow   <= 1'b0;
      o_rd_data    <= 8'h00;
      o_rd_vld     <= 1'b0;
      o_rxcmd      <= 8'h00;
      o_rxcmd_vld  <= 1'b0;
      o_pkt_end    <= 1'b0;
      seen_byte    <= 1'b0;
`ifdef ULPI_RX_STATS_EN
      o_pkt_total  <= 16'h0000;
      o_drop_total <= 16'h0000;
`endif
    end else begin
      state       <= state_n;
      o_rd_vld    <= 1'b0;
      o_rxcmd_vld <= cmd_req;
      if (cmd_req) o_rxcmd <= i_data;

      o_pkt_end <= end_req && seen_byte;
      if (end_req)       seen_byte <= 1'b0;
      else if (push_req) seen_byte <= 1'b1;

      // Flush wins over any push or pop in the same cycle.
      if (i_clr) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        o_count    <= '0;
        o_empty    <= 1'b1;
        o_full     <= 1'b0;
        o_overflow <= 1'b0;
      end else begin
        if (pop_ok) begin
          o_rd_data <= mem[rd_ptr];
          o_rd_vld  <= 1'b1;
          rd_ptr    <= rd_ptr + AW'(1);
        end
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (drop)    o_overflow <= 1'b1;
        o_count <= count_n;
        o_empty <= (count_n == '0);
        o_full  <= (count_n == CNT_W'(DEPTH));
      end

`ifdef ULPI_RX_STATS_EN
      if (i_clr) begin
        o_pkt_total  <= 16'h0000;
        o_drop_total <= 16'h0000;
      end else begin
        if (end_req && seen_byte && (o_pkt_total != 16'hFFFF))
          o_pkt_total <= o_pkt_total + 16'd1;
        if (drop && (o_drop_total != 16'hFFFF))
          o_drop_total <= o_drop_total + 16'd1;
      end
`endif
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (push_ok && !i_clr) mem[wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_ulpi_rx_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_ulpi_rx_buf
// Purpose  : Self-checking bench for ulpi_rx_buf. The reference model keeps
//            the FIFO as a byte queue and derives every expected output from
//            what the bench itself puts on the bus (it knows which cycles are
//            turnaround, RX CMD or packet bytes because it generates them).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ulpi_rx_buf;

  // Small depth so full/overflow/wrap are reached quickly.
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef ULPI_RX_STATS_EN
  localparam int VW = CNT_W + 22 + 32;
`else
  localparam int VW = CNT_W + 22;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             dir = 1'b0, nxt = 1'b0, clr = 1'b0, rd_en = 1'b0;
  logic [7:0]       data = 8'h00;
  logic [7:0]       rd_data, rxcmd;
  logic             rd_vld, empty, full, overflow, rxcmd_vld, pkt_end;
  logic [CNT_W-1:0] count;
`ifdef ULPI_RX_STATS_EN
  logic [15:0]      pkt_total, drop_total;
`endif

  always #5 clk = ~clk;

  ulpi_rx_buf #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dir(dir), .i_nxt(nxt), .i_data(data),
    .i_clr(clr), .i_rd_en(rd_en), .o_rd_data(rd_data), .o_rd_vld(rd_vld),
    .o_count(count), .o_empty(empty), .o_full(full), .o_overflow(overflow),
    .o_rxcmd(rxcmd), .o_rxcmd_vld(rxcmd_vld),
`ifdef ULPI_RX_STATS_EN
    .o_pkt_total(pkt_total), .o_drop_total(drop_total),
`endif
    .o_pkt_end(pkt_end)
  );

  // ---------------- reference model ----------------
  logic [7:0] q[$];
  logic       m_ovf, m_rd_vld, m_rxcmd_vld, m_pkt_end;
  logic [7:0] m_rd_data, m_rxcmd;
  int         m_pkt_total, m_drop_total;
  int         passed = 0, total = 0;

  logic [VW-1:0] obs;
`ifdef ULPI_RX_STATS_EN
  assign obs = {count, empty, full, overflow, rd_vld, rd_data, rxcmd_vld,
                rxcmd, pkt_end, pkt_total, drop_total};
`else
  assign obs = {count, empty, full, overflow, rd_vld, rd_data, rxcmd_vld,
                rxcmd, pkt_end};
`endif

  function automatic logic [VW-1:0] exp_vec();
`ifdef ULPI_RX_STATS_EN
    return {CNT_W'(q.size()), q.size() == 0, q.size() == DEPTH, m_ovf,
            m_rd_vld, m_rd_data, m_rxcmd_vld, m_rxcmd, m_pkt_end,
            16'(m_pkt_total), 16'(m_drop_total)};
`else
    return {CNT_W'(q.size()), q.size() == 0, q.size() == DEPTH, m_ovf,
            m_rd_vld, m_rd_data, m_rxcmd_vld, m_rxcmd, m_pkt_end};
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_rd_vld = 0; m_rxcmd_vld = 0; m_pkt_end = 0;
    m_rd_data = 8'h00; m_rxcmd = 8'h00;
    m_pkt_total = 0; m_drop_total = 0;
  endtask

  // Drive one cycle and advance the model by the rules for that cycle.
  // is_byte / is_cmd / is_end say what the bench intends the cycle to be.
  task automatic step(input logic d, input logic n, input logic [7:0] v,
                      input logic rd, input logic c, input logic is_byte,
                      input logic is_cmd, input logic is_end);
    dir = d; nxt = n; data = v; rd_en = rd; clr = c;
    m_rd_vld    = 0;
    m_rxcmd_vld = is_cmd;
    if (is_cmd) m_rxcmd = v;
    m_pkt_end = is_end;
    if (is_end && m_pkt_total < 16'hFFFF) m_pkt_total++;
    if (c) begin
      q.delete(); m_ovf = 0; m_pkt_total = 0; m_drop_total = 0;
    end else begin
      if (rd && q.size() > 0) begin
        m_rd_data = q.pop_front();
        m_rd_vld  = 1;
      end
      if (is_byte) begin
        if (q.size() < DEPTH) q.push_back(v);
        else begin
          m_ovf = 1;
          if (m_drop_total < 16'hFFFF) m_drop_total++;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  // Stimulus shorthands (no checking inside)
  task automatic ign(input logic d, input logic rd);   // non-capturing cycle
    step(d, 1'($urandom), 8'($urandom), rd, 0, 0, 0, 0);
  endtask
  task automatic beat(input logic n, input logic [7:0] v, input logic rd);
    step(1, n, v, rd, 0, n, !n, 0);
  endtask
  task automatic turn_end(input logic any, input logic rd);
    step(0, 1'($urandom), 8'($urandom), rd, 0, 0, 0, any);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; dir = 1; nxt = 1; rd_en = 1; data = 8'h77;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== exp_vec()) $display("FAIL reset_values got=%h exp=%h", obs, exp_vec());
    else passed++;
    dir = 0; nxt = 0; rd_en = 0;
    #2 rst_n = 1;
    @(posedge clk); #1;
    ign(0, 1);   // pop on empty after reset: no strobe
    total++;
    if (obs !== exp_vec()) $display("FAIL reset_release got=%h exp=%h", obs, exp_vec());
    else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] pk[3] = '{8'hA5, 8'h5A, 8'hC3};
    ign(1, 0); ign(1, 0);
    beat(0, 8'h4D, 0);
    total++;
    if (rxcmd_vld !== 1'b1 || rxcmd !== 8'h4D)
      $display("FAIL basic_rxcmd got=%b/%h exp=1/4d", rxcmd_vld, rxcmd);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      beat(1, pk[i], 0);
      total++;
      if (obs !== exp_vec()) $display("FAIL basic_byte%0d got=%h exp=%h", i, obs, exp_vec());
      else passed++;
    end
    turn_end(1, 0);
    total++;
    if (pkt_end !== 1'b1 || count !== CNT_W'(3))
      $display("FAIL basic_end got pkt_end=%b count=%0d exp 1/3", pkt_end, count);
    else passed++;
    ign(0, 0);
    total++;
    if (pkt_end !== 1'b0) $display("FAIL basic_end_once got=%b exp=0", pkt_end);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      ign(0, 1);
      total++;
      if (obs !== exp_vec() || (i < 3 && rd_data !== pk[i]) || (i == 3 && rd_vld !== 1'b0))
        $display("FAIL basic_pop%0d got=%h exp=%h", i, obs, exp_vec());
      else passed++;
    end
  endtask

  task automatic test_overflow();
    ign(1, 0); ign(1, 0);
    for (int i = 1; i <= 6; i++) begin
      beat(1, 8'(i), 0);
      total++;
      if (obs !== exp_vec()) $display("FAIL ovf_byte%0d got=%h exp=%h", i, obs, exp_vec());
      else passed++;
    end
    turn_end(1, 0);
    total++;
    if (full !== 1'b1 || overflow !== 1'b1 || obs !== exp_vec())
      $display("FAIL ovf_status got=%h exp=%h", obs, exp_vec());
    else passed++;
`ifdef ULPI_RX_STATS_EN
    total++;
    if (drop_total !== 16'd2) $display("FAIL ovf_drop_total got=%0d exp=2", drop_total);
    else passed++;
`endif
  endtask

  task automatic test_full_push_pop();
    ign(1, 0); ign(1, 0);
    beat(1, 8'h07, 1);
    total++;
    if (rd_vld !== 1'b1 || rd_data !== 8'h01 || count !== CNT_W'(4) || obs !== exp_vec())
      $display("FAIL fullpp got=%h exp=%h", obs, exp_vec());
    else passed++;
    turn_end(1, 0);
    for (int i = 0; i < 5; i++) begin
      ign(0, 1);
      total++;
      if (obs !== exp_vec()) $display("FAIL fullpp_drain%0d got=%h exp=%h", i, obs, exp_vec());
      else passed++;
    end
    total++;
    if (m_rd_data !== 8'h07 || rd_data !== 8'h07)
      $display("FAIL fullpp_last got=%h exp=07", rd_data);
    else passed++;
  endtask

  task automatic test_cmd_only_clr();
    ign(1, 0); ign(1, 0);
    beat(1, 8'h3C, 0); beat(1, 8'h3D, 0);
    turn_end(1, 0);
    ign(1, 0); ign(1, 0);
    for (int i = 0; i < 3; i++) begin
      beat(0, 8'($urandom), 0);
      total++;
      if (obs !== exp_vec() || rxcmd_vld !== 1'b1)
        $display("FAIL cmdonly%0d got=%h exp=%h", i, obs, exp_vec());
      else passed++;
    end
    turn_end(0, 0);
    total++;
    if (pkt_end !== 1'b0 || count !== CNT_W'(2) || obs !== exp_vec())
      $display("FAIL cmdonly_end got=%h exp=%h", obs, exp_vec());
    else passed++;
    step(0, 0, 8'h00, 1, 1, 0, 0, 0);   // flush wins over same-cycle pop
    total++;
    if (count !== '0 || overflow !== 1'b0 || empty !== 1'b1 || rd_vld !== 1'b0 || obs !== exp_vec())
      $display("FAIL clr got=%h exp=%h", obs, exp_vec());
    else passed++;
  endtask

  task automatic test_reset_mid_packet();
    ign(1, 0); ign(1, 0);
    beat(1, 8'hAA, 0); beat(1, 8'hBB, 0);
    rst_n = 0;
    model_reset();
    #2;
    total++;
    if (obs !== exp_vec()) $display("FAIL midrst_async got=%h exp=%h", obs, exp_vec());
    else passed++;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'($urandom), 0, 0, 0, 0, 0);   // tail of old packet: not captured
      total++;
      if (obs !== exp_vec()) $display("FAIL midrst_tail%0d got=%h exp=%h", i, obs, exp_vec());
      else passed++;
    end
    turn_end(0, 0);
    ign(1, 0); ign(1, 0);
    beat(1, 8'h11, 0); beat(1, 8'h22, 0);
    turn_end(1, 0);
    total++;
    if (count !== CNT_W'(2) || pkt_end !== 1'b1 || obs !== exp_vec())
      $display("FAIL midrst_new got=%h exp=%h", obs, exp_vec());
    else passed++;
    for (int i = 0; i < 3; i++) begin
      ign(0, 1);
      total++;
      if (obs !== exp_vec()) $display("FAIL midrst_pop%0d got=%h exp=%h", i, obs, exp_vec());
      else passed++;
    end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    ign(1, 1); ign(1, 1);
    while (pushed < 20) begin
      logic n = ($urandom_range(0, 4) != 0);
      beat(n, 8'($urandom), 1'($urandom_range(0, 2) != 0));
      if (n) pushed++;
      total++;
      if (obs !== exp_vec()) $display("FAIL wrap_beat%0d got=%h exp=%h", pushed, obs, exp_vec());
      else passed++;
    end
    turn_end(1, 1);
    for (int i = 0; i < DEPTH + 2; i++) begin
      ign(0, 1);
      total++;
      if (obs !== exp_vec()) $display("FAIL wrap_drain%0d got=%h exp=%h", i, obs, exp_vec());
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 12; t++) begin
      int  nb  = $urandom_range(0, 7);
      logic any = 0;
      ign(1, 1'($urandom_range(0, 3) == 0));
      ign(1, 1'($urandom_range(0, 3) == 0));
      for (int b = 0; b < nb; b++) begin
        logic n = 1'($urandom);
        any |= n;
        beat(n, 8'($urandom), 1'($urandom_range(0, 2) == 0));
        total++;
        if (obs !== exp_vec()) $display("FAIL b2b_t%0d_b%0d got=%h exp=%h", t, b, obs, exp_vec());
        else passed++;
      end
      turn_end(any, 1'($urandom));
      total++;
      if (obs !== exp_vec()) $display("FAIL b2b_end%0d got=%h exp=%h", t, obs, exp_vec());
      else passed++;
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        step(0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0), 0, 0, 0);
        total++;
        if (obs !== exp_vec()) $display("FAIL b2b_gap%0d got=%h exp=%h", t, obs, exp_vec());
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_cmd_only_clr();
    test_reset_mid_packet();
    test_wrap();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ulpi_rx_buf.md
ULPI_RX_BUF -- requirements
Module: ulpi_rx_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 32, receive FIFO depth in bytes; power of two, 4..1024.
REQ-002 SHALL derive localparam CNT_W = $clog2(DEPTH)+1 for count width.
REQ-003 i_clk  input  1  ULPI 60 MHz clock; sole clock; all logic on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_dir  input  1  ULPI DIR from PHY.
REQ-006 i_nxt  input  1  ULPI NXT from PHY.
REQ-007 i_data  input  8  ULPI DATA as sampled from the bus.
REQ-008 i_clr  input  1  synchronous flush of FIFO and sticky overflow flag.
REQ-009 i_rd_en  input  1  pop request from consumer.
REQ-010 o_rd_data  output  8  popped byte, registered.
REQ-011 o_rd_vld  output  1  o_rd_data valid strobe, one cycle.
REQ-012 o_count  output  CNT_W  bytes currently held.
REQ-013 o_empty / o_full  output  1 each  o_count==0 / o_count==DEPTH.
REQ-014 o_overflow  output  1  sticky: a packet byte was dropped.
REQ-015 o_rxcmd  output  8  last RX CMD byte; o_rxcmd_vld  output  1  one-cycle strobe on update.
REQ-016 o_pkt_end  output  1  one-cycle pulse at end of a bus turn that carried at least one packet byte.

Function
REQ-017 SHALL implement FSM states SYNC, IDLE, TURN, RECV.
REQ-018 SYNC: after reset; -> IDLE when i_dir==0; no bytes captured while in SYNC (reset mid-packet never captures a partial tail).
REQ-019 IDLE: i_dir==1 -> TURN; else stay.
REQ-020 TURN: turnaround cycle, i_data ignored; i_dir==1 -> RECV; i_dir==0 -> IDLE.
REQ-021 RECV, i_dir==1, i_nxt==1: i_data is a packet byte, pushed into FIFO.
REQ-022 RECV, i_dir==1, i_nxt==0: i_data is an RX CMD; o_rxcmd <= i_data, o_rxcmd_vld pulses next cycle.
REQ-023 RECV, i_dir==0: turnaround, i_data ignored, -> IDLE; o_pkt_end pulses next cycle if at least one packet byte (stored or dropped) arrived in that turn.
REQ-024 Push while full (without simultaneous pop): byte dropped, o_overflow set next cycle, held until i_clr or reset.
REQ-025 i_rd_en while o_empty==0: head byte to o_rd_data and o_rd_vld=1 next cycle; latency 1.
REQ-026 i_rd_en while empty: ignored, o_rd_vld=0, o_rd_data holds.
REQ-027 Simultaneous push and pop: both succeed, including when full or empty-with-write-bypass not allowed (empty pop ignored, push stored); o_count net change 0 when full.
REQ-028 Pointers SHALL wrap modulo DEPTH; byte order preserved across wrap.
REQ-029 i_clr SHALL zero pointers, o_count, o_overflow next cycle; takes priority over same-cycle push/pop; FSM state, o_rxcmd unaffected.
REQ-030 o_count, o_empty, o_full, o_overflow SHALL be registered and reflect the previous cycle's operations.

Reset
REQ-031 On i_rst_n==0, asynchronously: FSM=SYNC, pointers=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, o_rd_data=8'h00, o_rd_vld=0, o_rxcmd=8'h00, o_rxcmd_vld=0, o_pkt_end=0.
REQ-032 FIFO storage contents need not be reset.

Configuration
REQ-033 Macro ULPI_RX_STATS_EN defined: SHALL add outputs o_pkt_total[15:0] (o_pkt_end pulses) and o_drop_total[15:0] (dropped bytes), both saturating at 16'hFFFF, reset to 0, cleared by i_clr.
REQ-034 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-035 DEPTH=32; dir up, TURN, RX CMD 8'h4D, bytes A5,5A,C3, dir down -> o_rxcmd=4D with strobe, o_count=3, one o_pkt_end, pops return A5,5A,C3 in order.
REQ-036 DEPTH=4; 6-byte packet 01..06, no pops -> FIFO holds 01..04, o_full=1, o_overflow=1, (stats) o_drop_total=2.
REQ-037 Full FIFO, push 07 and pop same cycle -> pop returns oldest byte, o_count stays 4, 07 stored last.
REQ-038 Reset asserted mid-packet with i_dir held 1, bytes continue 3 cycles, then dir falls and new packet 11,22 -> only 11,22 captured, outputs equal reset values during reset.
REQ-039 Bus turn with RX CMD only (nxt never 1) -> o_rxcmd_vld pulses, no o_pkt_end, o_count unchanged; i_clr after overflow -> o_count=0, o_overflow=0, o_empty=1.
REQ-040 DEPTH=8; 20 bytes pushed/popped interleaved -> pointer wrap, order intact, pops on empty give no o_rd_vld.
